// File: rtl/adder_result_collector.sv
// adder_result_collector
//   Captures each valid adder result (10-bit sum plus carry-out) into a small
//   first-word-fall-through FIFO, hands results downstream over valid/ready,
//   and keeps a saturating running total of every accepted result.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_valid     result strobe from the adder
//   i_result    adder result, sampled only when i_valid=1
//   o_valid     FIFO head valid
//   i_ready     downstream ready
//   o_data      FIFO head data
//   o_count     number of stored entries
//   o_full      o_count == DEPTH
//   o_empty     o_count == 0
//   o_overflow  sticky: a result was dropped because the FIFO was full
//   i_clr_acc   synchronous clear of the running total and saturation flag
//   o_acc       saturating sum of accepted results
//   o_acc_sat   sticky: o_acc has saturated
module adder_result_collector #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_result,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  input  logic              i_clr_acc,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_acc_sat
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ACC_W-1:0] AccMax = {ACC_W{1'b1}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              acc_sat_q, acc_sat_d;

  logic              pop;
  logic              push;
  logic [ACC_W:0]    acc_sum;

  assign o_count    = count_q;
  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_valid    = !o_empty;
  assign o_data     = mem_q[rd_ptr_q];
  assign o_overflow = overflow_q;
  assign o_acc      = acc_q;
  assign o_acc_sat  = acc_sat_q;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop  = o_valid & i_ready;
  assign push = i_valid & (!o_full | pop);

  // One extra bit so the carry out of the add exposes saturation.
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(i_result);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // Pointers wrap modulo DEPTH
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (i_valid && o_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    if (i_clr_acc) begin
      acc_d     = push ? ACC_W'(i_result) : '0;
      acc_sat_d = 1'b0;
    end else if (push) begin
      if (acc_sum[ACC_W]) begin
        acc_d     = AccMax;
        acc_sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
      acc_sat_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      acc_q      <= acc_d;
      acc_sat_q  <= acc_sat_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      mem_q[wr_ptr_q] <= i_result;
    end
  end

endmodule

// File: tb/tb_adder_result_collector.sv
module tb_adder_result_collector;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_W-1:0] result_in;
  logic              valid_out;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              clr_acc;
  logic [ACC_W-1:0]  acc;
  logic              acc_sat;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  adder_result_collector #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid_in),
    .i_result  (result_in),
    .o_valid   (valid_out),
    .i_ready   (ready),
    .o_data    (data_out),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty),
    .o_overflow(overflow),
    .i_clr_acc (clr_acc),
    .o_acc     (acc),
    .o_acc_sat (acc_sat)
  );

  // Monitor: every handshake on the output side pops one expected value.
  always @(negedge clk) begin
    if (!rst && valid_out === 1'b1 && ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected actual=%0d required=none", data_out);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL pop_data actual=%0d required=%0d", data_out, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted push: the value is expected to come out later.
  task automatic push_exp(input logic [DATA_W-1:0] v);
    valid_in  = 1'b1;
    result_in = v;
    exp_q.push_back(v);
    tick();
    valid_in  = 1'b0;
    result_in = 'x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    ready = 1'b1;
    while (empty !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, {31'd0, empty}, 32'd1);
    chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; result_in = 'x; ready = 1'b0; clr_acc = 1'b0;
    do_reset();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_acc", acc, 0);
    chk("rst_sat", acc_sat, 0);

    // Two results separated by idle cycles, each visible for one cycle
    ready = 1'b1;
    chk("t1_pre_valid", valid_out, 0);
    push_exp(11'd61);
    chk("t1_61_valid", valid_out, 1);
    chk("t1_61_data", data_out, 61);
    tick();
    chk("t1_61_gone", valid_out, 0);
    repeat (3) tick();
    push_exp(11'd98);
    chk("t1_98_valid", valid_out, 1);
    chk("t1_98_data", data_out, 98);
    tick();
    chk("t1_98_gone", valid_out, 0);
    chk("t1_acc", acc, 159);
    chk("t1_ovf", overflow, 0);

    // Fill, overflow drop, drain
    clr_acc = 1'b1; tick(); clr_acc = 1'b0;
    chk("t2_acc_clr", acc, 0);
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_exp(DATA_W'(i));
    chk("t2_full", full, 1);
    chk("t2_count", count, 4);
    valid_in = 1'b1; result_in = 11'd5; tick(); valid_in = 1'b0;
    chk("t2_ovf", overflow, 1);
    chk("t2_count_after_drop", count, 4);
    drain("t2");
    chk("t2_acc", acc, 10);

    // Push into full FIFO with simultaneous pop
    do_reset();
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_exp(DATA_W'(i));
    ready = 1'b1;
    exp_q.push_back(11'd9);
    valid_in = 1'b1; result_in = 11'd9; tick(); valid_in = 1'b0;
    chk("t3_count", count, 4);
    chk("t3_ovf", overflow, 0);
    drain("t3");

    // Accumulator saturation and clear
    clr_acc = 1'b1; tick(); clr_acc = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 32; i++) push_exp(11'd2047);
    chk("t4_acc32", acc, 65504);
    chk("t4_sat32", acc_sat, 0);
    push_exp(11'd2047);
    chk("t4_acc33", acc, 65535);
    chk("t4_sat33", acc_sat, 1);
    tick();
    clr_acc = 1'b1; tick(); clr_acc = 1'b0;
    chk("t4_clr_acc", acc, 0);
    chk("t4_clr_sat", acc_sat, 0);
    clr_acc = 1'b1; push_exp(11'd7); clr_acc = 1'b0;
    chk("t4_clr_push_acc", acc, 7);
    drain("t4");

    // Reset mid-operation with a push pending
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; result_in = DATA_W'(11 + i); tick();
    end
    chk("t5_count_pre", count, 3);
    rst = 1'b1; result_in = 11'd14; tick();
    rst = 1'b0; valid_in = 1'b0; result_in = 'x;
    exp_q.delete();
    chk("t5_count", count, 0);
    chk("t5_valid", valid_out, 0);
    chk("t5_acc", acc, 0);
    chk("t5_ovf", overflow, 0);
    ready = 1'b1;
    repeat (4) tick();
    chk("t5_still_empty", valid_out, 0);

    // No bypass on empty, then wrap-around ordering
    valid_in = 1'b1; result_in = 11'd20;
    #1;
    chk("t6_no_bypass", valid_out, 0);
    exp_q.push_back(11'd20);
    tick(); valid_in = 1'b0; result_in = 'x;
    chk("t6_valid_next", valid_out, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      push_exp(DATA_W'(100 + i * 37));
      tick();
    end
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
